// File: rtl/prbs26_checker.sv
`default_nettype none
// ============================================================================
// Module  : prbs26_checker
// Brief   : Self-synchronising checker for the 26-bit parallel LFSR stream;
//           hunts, locks, then counts sequence errors with a flywheel reference.
// Revision: 1.0 - initial release
// ============================================================================
module prbs26_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [1:26]      din,
    input  logic             resync,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] c_lock_cnt = 8'(LOCK_CNT);
    localparam logic [7:0] c_loss_cnt = 8'(LOSS_CNT);

    state_t      r_state;
    logic [1:26] r_ref;
    logic [7:0]  r_match_cnt;
    logic [7:0]  r_miss_cnt;

    logic [1:26] w_exp;
    logic        w_match;
    logic        w_err_evt;

    // The all-zero state is a lock-up point of the LFSR, so it is kicked to 1.
    always_comb begin
        w_exp = '0;
        if (r_ref == '0) begin
            w_exp[26] = 1'b1;
        end else begin
            w_exp[1]     = r_ref[26];
            w_exp[2]     = r_ref[1] ^ r_ref[26];
            w_exp[3:7]   = r_ref[2:6];
            w_exp[8]     = r_ref[7] ^ r_ref[26];
            w_exp[9]     = r_ref[8] ^ r_ref[26];
            w_exp[10:26] = r_ref[9:25];
        end
    end

    assign w_match   = (din == w_exp);
    assign w_err_evt = din_valid & ~resync & (r_state == ST_LOCKED) & ~w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_ref       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            err <= 1'b0;

            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (w_err_evt && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end

            if (resync) begin
                r_state     <= ST_HUNT;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                locked      <= 1'b0;
            end else if (din_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (din != '0) begin
                            r_ref       <= din;
                            r_match_cnt <= '0;
                            r_state     <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        r_ref <= din;
                        if (!w_match) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt + 8'd1 == c_lock_cnt) begin
                            r_match_cnt <= '0;
                            r_miss_cnt  <= '0;
                            r_state     <= ST_LOCKED;
                            locked      <= 1'b1;
                        end else begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_ref      <= din;
                            r_miss_cnt <= '0;
                        end else begin
                            // Flywheel: advance on the prediction so one bad word costs one error.
                            r_ref <= w_exp;
                            err   <= 1'b1;
                            if (r_miss_cnt + 8'd1 == c_loss_cnt) begin
                                r_miss_cnt <= '0;
                                r_state    <= ST_HUNT;
                                locked     <= 1'b0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs26_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_prbs26_checker
// Brief   : Directed self-checking bench for prbs26_checker (ERR_W 16 and 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_prbs26_checker;

    typedef logic [1:26] word_t;

    logic        clk;
    logic        rst_n;
    logic        din_valid;
    word_t       din;
    logic        resync;
    logic        clr_cnt;
    logic        locked16, err16, locked4, err4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_errors = 0;
    word_t cur;

    prbs26_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .resync(resync), .clr_cnt(clr_cnt),
        .locked(locked16), .err(err16), .err_cnt(cnt16)
    );

    prbs26_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .resync(resync), .clr_cnt(clr_cnt),
        .locked(locked4), .err(err4), .err_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t nxt(input word_t s);
        word_t n;
        n = '0;
        if (s == '0) begin
            n[26] = 1'b1;
        end else begin
            n[1] = s[26];
            n[2] = s[1] ^ s[26];
            for (int k = 3; k <= 7; k++) n[k] = s[k-1];
            n[8] = s[7] ^ s[26];
            n[9] = s[8] ^ s[26];
            for (int k = 10; k <= 26; k++) n[k] = s[k-1];
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic send(input word_t w, input logic v, input logic rs, input logic cc);
        @(negedge clk);
        din       = w;
        din_valid = v;
        resync    = rs;
        clr_cnt   = cc;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        resync    = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic send_clean();
        cur = nxt(cur);
        send(cur, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_bad(input word_t mask, input logic cc);
        cur = nxt(cur);
        send(cur ^ mask, 1'b1, 1'b0, cc);
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; din = '0; resync = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", {31'd0, locked16}, 32'd0);
        chk("rst_err", {31'd0, err16}, 32'd0);
        chk("rst_cnt", {16'd0, cnt16}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Test 1: first two words are 26'h0000001 and 26'h3060000
        cur = 26'h0000001;
        send(cur, 1'b1, 1'b0, 1'b0);
        cur = 26'h3060000;
        send(cur, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i <= 8; i++) send_clean();
        chk("t1_not_locked_8", {31'd0, locked16}, 32'd0);
        send_clean();
        chk("t1_locked_9", {31'd0, locked16}, 32'd1);
        chk("t1_err", {31'd0, err16}, 32'd0);
        chk("t1_cnt", {16'd0, cnt16}, 32'd0);

        // Test 2: single bit-5 flip
        send_bad(word_t'(26'h0200000), 1'b0);
        chk("t2_err", {31'd0, err16}, 32'd1);
        chk("t2_cnt", {16'd0, cnt16}, 32'd1);
        chk("t2_locked", {31'd0, locked16}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_clean();
            chk("t2_clean_err", {31'd0, err16}, 32'd0);
        end
        chk("t2_cnt_hold", {16'd0, cnt16}, 32'd1);

        // Test 3: four garbage words drop lock, then relock
        send('0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", {16'd0, cnt16}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            send_bad(word_t'(26'h2AAAAAA), 1'b0);
            chk("t3_err", {31'd0, err16}, 32'd1);
            chk("t3_still_locked", {31'd0, locked16}, 32'd1);
        end
        send_bad(word_t'(26'h1555555), 1'b0);
        chk("t3_err4", {31'd0, err16}, 32'd1);
        chk("t3_cnt4", {16'd0, cnt16}, 32'd4);
        chk("t3_unlocked", {31'd0, locked16}, 32'd0);
        for (int i = 1; i <= 8; i++) send_clean();
        chk("t3_relock_8", {31'd0, locked16}, 32'd0);
        send_clean();
        chk("t3_relock_9", {31'd0, locked16}, 32'd1);

        // Test 4: resync, zeros in HUNT, then gapped stream
        send('0, 1'b0, 1'b1, 1'b0);
        chk("t4_resync", {31'd0, locked16}, 32'd0);
        for (int i = 0; i < 3; i++) send('0, 1'b1, 1'b0, 1'b0);
        chk("t4_zero_err", {31'd0, err16}, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            send_clean();
            send(word_t'(26'h0F0F0F0), 1'b0, 1'b0, 1'b0);
            if (i == 8) chk("t4_gap_8", {31'd0, locked16}, 32'd0);
        end
        chk("t4_gap_9", {31'd0, locked16}, 32'd1);
        chk("t4_gap_err", {31'd0, err16}, 32'd0);
        chk("t4_cnt", {16'd0, cnt16}, 32'd4);

        // Test 5: saturation on the 4-bit counter and clear-wins
        send('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send_bad(word_t'(26'h0000100), 1'b0);
            send_clean();
        end
        chk("t5_sat4", {28'd0, cnt4}, 32'd15);
        chk("t5_cnt16", {16'd0, cnt16}, 32'd20);
        chk("t5_locked", {31'd0, locked4}, 32'd1);
        send_bad(word_t'(26'h0000100), 1'b1);
        chk("t5_clr_err", {31'd0, err4}, 32'd1);
        chk("t5_clr_cnt4", {28'd0, cnt4}, 32'd0);
        chk("t5_clr_cnt16", {16'd0, cnt16}, 32'd0);

        // Test 6: async reset mid-lock, then resync while locked
        send_clean();
        send_bad(word_t'(26'h0000001), 1'b0);
        chk("t6_pre_cnt", {16'd0, cnt16}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_locked", {31'd0, locked16}, 32'd0);
        chk("t6_async_cnt", {16'd0, cnt16}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 9; i++) send_clean();
        chk("t6_relock", {31'd0, locked16}, 32'd1);
        send_bad(word_t'(26'h0000010), 1'b0);
        chk("t6_cnt1", {16'd0, cnt16}, 32'd1);
        cur = nxt(cur);
        send(cur ^ word_t'(26'h3000000), 1'b1, 1'b1, 1'b0);
        chk("t6_resync_locked", {31'd0, locked16}, 32'd0);
        chk("t6_resync_err", {31'd0, err16}, 32'd0);
        chk("t6_resync_cnt", {16'd0, cnt16}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
